// File: rtl/serial_comparator.sv
// Bit-serial WIDTH-bit magnitude comparator driving an external comparator1bit, MSB first.
// Optional `SERIAL_CMP_EARLY_EXIT_EN: finish as soon as the first differing bit is seen.
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             dec_lt;
  logic             dec_gt;
  logic             nxt_lt;
  logic             nxt_gt;
  logic             last_bit;

  // The first differing bit wins; simultaneous lt/gt resolves to LT.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_lt   = dec_lt;
    nxt_gt   = dec_gt;
    last_bit = 1'b0;
    if (!dec_lt && !dec_gt) begin
      if (cmp_lt)      nxt_lt = 1'b1;
      else if (cmp_gt) nxt_gt = 1'b1;
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    last_bit = (cnt == '0) || nxt_lt || nxt_gt;
`else
    last_bit = (cnt == '0);
`endif
  end

  assign cmp_a = (state == SHIFT) && sa[WIDTH-1];
  assign cmp_b = (state == SHIFT) && sb[WIDTH-1];
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      dec_lt <= 1'b0;
      dec_gt <= 1'b0;
      a_lt_b <= 1'b0;
      a_gt_b <= 1'b0;
      a_eq_b <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            cnt    <= CW'(WIDTH - 1);
            dec_lt <= 1'b0;
            dec_gt <= 1'b0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sa     <= sa << 1;
          sb     <= sb << 1;
          cnt    <= cnt - CW'(1);
          dec_lt <= nxt_lt;
          dec_gt <= nxt_gt;
          if (last_bit) begin
            state  <= DONE;
            a_lt_b <= nxt_lt;
            a_gt_b <= nxt_gt;
            a_eq_b <= !(nxt_lt || nxt_gt);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
